// File: rtl/spi_cfg_pkg.sv
// Shared constants, state encoding and step clamping for the SPI divider configuration slave.
package spi_cfg_pkg;

    localparam logic [7:0] CMD_WR_STEP = 8'h01;
    localparam logic [7:0] CMD_RD_STEP = 8'h02;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned CMD_BITS   = 8;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

    function automatic logic [15:0] clamp_step(input logic [15:0] data, input logic [15:0] min_step);
        return (data < min_step) ? min_step : data;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with registered single-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {2{RST_VAL}};
            prev <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            prev <= sync[1];
            rise <= sync[1] & ~prev;
            fall <= ~sync[1] & prev;
        end
    end

    assign level = sync[1];

endmodule

// File: rtl/spi_div_cfg.sv
// Mode-0 SPI slave holding the divider step register: 24-bit frames of 8-bit command plus 16-bit data.
module spi_div_cfg
    import spi_cfg_pkg::*;
#(
    parameter logic [15:0] DEF_STEP = 16'd3,
    parameter logic [15:0] MIN_STEP = 16'd1
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] div_step,
    output logic        cfg_update,
    output logic        frame_err
);

    localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
    localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic [1:0] mosi_sync;
    logic       mosi_bit;

    state_t      state, state_nx;
    logic [4:0]  bit_cnt;
    logic [14:0] sh;
    logic [7:0]  cmd_q;
    logic [15:0] rd_sh;

    logic cs_high, start, abort, shift_en, cmd_done, commit, miso_shift;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
        .clk   (clk_in),
        .rst   (rst),
        .din   (spi_sck),
        .level (sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // CS resets to the deasserted level so reset never fabricates a frame start.
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk   (clk_in),
        .rst   (rst),
        .din   (spi_cs_n),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign mosi_bit = mosi_sync[1];
    assign cs_high  = cs_lvl | cs_rise;

    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        abort      = 1'b0;
        shift_en   = 1'b0;
        cmd_done   = 1'b0;
        commit     = 1'b0;
        miso_shift = 1'b0;
        case (state)
            IDLE: begin
                // Mode 0 idles SCK low; waiting for it avoids counting a half pulse.
                if (!cs_lvl && !sck_lvl) begin
                    start    = 1'b1;
                    state_nx = CMD;
                end
            end
            CMD: begin
                if (cs_high) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else if (sck_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CMD_LAST) begin
                        cmd_done = 1'b1;
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (cs_high) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    if (sck_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == FRAME_LAST) begin
                            commit   = 1'b1;
                            state_nx = DONE;
                        end
                    end
                    if (sck_fall && cmd_q == CMD_RD_STEP) begin
                        miso_shift = 1'b1;
                    end
                end
            end
            DONE: begin
                if (cs_high) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            mosi_sync  <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            cmd_q      <= '0;
            rd_sh      <= '0;
            div_step   <= DEF_STEP;
            spi_miso   <= 1'b0;
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            mosi_sync  <= {mosi_sync[0], spi_mosi};
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;

            if (start || cs_fall) begin
                bit_cnt <= '0;
                sh      <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 5'd1;
                sh      <= {sh[13:0], mosi_bit};
            end

            if (cmd_done) begin
                cmd_q <= {sh[6:0], mosi_bit};
                rd_sh <= div_step;
            end

            if (commit) begin
                if (cmd_q == CMD_WR_STEP) begin
                    div_step   <= clamp_step({sh, mosi_bit}, MIN_STEP);
                    cfg_update <= 1'b1;
                end else if (cmd_q != CMD_RD_STEP) begin
                    frame_err <= 1'b1;
                end
            end

            if (abort) begin
                frame_err <= 1'b1;
            end

            if (miso_shift) begin
                spi_miso <= rd_sh[15];
                rd_sh    <= {rd_sh[14:0], 1'b0};
            end else if (state_nx != DATA) begin
                spi_miso <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_div_cfg.sv
// Directed bench for spi_div_cfg: host-side SPI master with scoreboarded commits and MISO words.
module tb_spi_div_cfg;
    import spi_cfg_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] div_step;
    logic        cfg_update;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cfg_cnt = 0;
    int err_cnt = 0;

    logic [15:0] exp_q[$];
    logic [23:0] rd_q[$];

    spi_div_cfg #(.DEF_STEP(16'd3), .MIN_STEP(16'd1)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .div_step   (div_step),
        .cfg_update (cfg_update),
        .frame_err  (frame_err)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (!rst) begin
            if (frame_err) err_cnt++;
            if (cfg_update) begin
                logic [15:0] exp_step;
                cfg_cnt++;
                exp_step = 16'hxxxx;
                if (exp_q.size() != 0) exp_step = exp_q.pop_front();
                checks++;
                assert (div_step === exp_step) else begin
                    errors++;
                    $error("FAIL commit_step observed=%h expected=%h", div_step, exp_step);
                end
            end
        end
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // SCK = clk_in/10; host samples MISO on each SCK rise.
    task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] data, input int unsigned nbits,
                             input bit release_cs, output logic [23:0] rx);
        logic [23:0] tx;
        tx = {cmd, data};
        rx = '0;
        spi_cs_n = 1'b0;
        wait_clks(5);
        for (int unsigned i = 0; i < nbits; i++) begin
            spi_mosi = (i < 24) ? tx[5'(23 - i)] : 1'b0;
            wait_clks(5);
            spi_sck = 1'b1;
            if (i < 24) rx[5'(23 - i)] = spi_miso;
            wait_clks(5);
            spi_sck = 1'b0;
        end
        wait_clks(5);
        if (release_cs) begin
            spi_cs_n = 1'b1;
            wait_clks(12);
        end
    endtask

    task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [15:0] data,
                            input int unsigned nbits, input logic [23:0] exp_rx,
                            input int exp_cfg, input int exp_err, input logic [15:0] exp_step);
        int cfg0, err0;
        logic [23:0] rx, exp_word;
        cfg0 = cfg_cnt;
        err0 = err_cnt;
        rd_q.push_back(exp_rx);
        if (exp_cfg != 0) exp_q.push_back(exp_step);
        spi_frame(cmd, data, nbits, 1'b1, rx);
        exp_word = rd_q.pop_front();
        check({tag, "_miso"}, 32'(rx), 32'(exp_word));
        check({tag, "_cfg"}, 32'(cfg_cnt - cfg0), 32'(exp_cfg));
        check({tag, "_err"}, 32'(err_cnt - err0), 32'(exp_err));
        check({tag, "_step"}, 32'(div_step), 32'(exp_step));
    endtask

    initial begin
        logic [23:0] rx;
        int err0;
        rst      = 1'b1;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(1);
        check("rst_step", 32'(div_step), 32'h0003);
        check("rst_miso", 32'(spi_miso), 32'h0);
        check("rst_cfg",  32'(cfg_update), 32'h0);
        check("rst_err",  32'(frame_err), 32'h0);
        wait_clks(8);

        do_frame("wr_f9",   8'h01, 16'h00F9, 24, 24'h000000, 1, 0, 16'h00F9);
        do_frame("wr_zero", 8'h01, 16'h0000, 24, 24'h000000, 1, 0, 16'h0001);
        do_frame("wr_1234", 8'h01, 16'h1234, 24, 24'h000000, 1, 0, 16'h1234);
        do_frame("rd_1234", 8'h02, 16'hABCD, 24, 24'h001234, 0, 0, 16'h1234);
        do_frame("abort12", 8'h01, 16'h0777, 12, 24'h000000, 0, 1, 16'h1234);
        do_frame("wr_0050", 8'h01, 16'h0050, 24, 24'h000000, 1, 0, 16'h0050);
        do_frame("bad_7f",  8'h7F, 16'h5555, 26, 24'h000000, 0, 1, 16'h0050);
        do_frame("rd_0050", 8'h02, 16'h0000, 24, 24'h000050, 0, 0, 16'h0050);

        // Reset in the middle of a frame: CS still low when rst rises.
        err0 = err_cnt;
        spi_frame(8'h7F, 16'h0000, 10, 1'b0, rx);
        rst      = 1'b1;
        spi_cs_n = 1'b1;
        wait_clks(2);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        check("midrst_step",  32'(div_step), 32'h0003);
        rst = 1'b0;
        wait_clks(12);
        check("midrst_err",   32'(err_cnt - err0), 32'h0);
        check("midrst_idle",  32'(dut.state), 32'(IDLE));
        check("midrst_miso",  32'(spi_miso), 32'h0);

        check("commit_q_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
